uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 133 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter: one start bit, eight data bits LSB first, STOP_BITS stop bits.
// Every output comes straight from a flop, so there is no combinational path from input to output.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_aresetn,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = done_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                done_d = 1'b1;
                if (i_tx_start) begin
                    state_d   = START;
                    shift_d   = i_tx_data;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    done_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    // bit_idx is reused here to count stop bits
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b1;
            end
        endcase
        busy_d = ~done_d;
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer: frame-level reference model, serial loopback receiver,
// and literal waveform checks for the fixed cases.
module tb_uart_tx_serializer;

    localparam int CPB     = 4;
    localparam int FRAME_A = 10 * CPB;
    localparam int FRAME_B = 11 * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       start_a = 1'b0;
    logic [7:0] data_a  = '0;
    logic       start_b = 1'b0;
    logic [7:0] data_b  = '0;
    logic       tx_a, done_a, busy_a;
    logic       tx_b, done_b, busy_b;

    int total  = 0;
    int passed = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_aresetn(rst_n), .i_tx_start(start_a), .i_tx_data(data_a),
        .o_tx_done(done_a), .o_tx(tx_a), .o_busy(busy_a)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .i_clk(clk), .i_aresetn(rst_n), .i_tx_start(start_b), .i_tx_data(data_b),
        .o_tx_done(done_b), .o_tx(tx_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line level at position pos of a frame carrying byte d (start, 8 data LSB first, stop).
    function automatic logic frame_level(input int pos, input logic [7:0] d);
        int b;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Reference model: a frame is a fixed-length window starting at an accepting edge.
    bit         m_busy = 0;
    int         m_pos  = 0;
    logic [7:0] m_byte = '0;
    logic [7:0] rx_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0;
            m_pos  = 0;
            rx_q.delete();
        end else if (m_busy) begin
            m_pos++;
            if (m_pos == FRAME_A) m_busy = 0;
        end else if (start_a) begin
            m_busy = 1;
            m_pos  = 0;
            m_byte = data_a;
            rx_q.push_back(data_a);
        end
    end

    // Per-cycle comparison against the model, plus a count of frame starts seen on o_busy.
    bit cmp_en    = 0;
    int rises     = 0;
    int done_hi   = 0;
    bit busy_prev = 0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("model_tx",   tx_a,   m_busy ? frame_level(m_pos, m_byte) : 1'b1);
            check("model_done", done_a, !m_busy);
            check("model_busy", busy_a, m_busy);
        end
        if (busy_a && !busy_prev) rises++;
        busy_prev = busy_a;
        if (done_a) done_hi++;
    end

    // Loopback receiver: mid-bit sampling of o_tx, compared in order with accepted bytes.
    int         rx_cnt   = -1;
    int         rx_bytes = 0;
    logic [7:0] rx_sh    = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (tx_a == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_sh[rx_cnt/CPB-1] = tx_a;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                check("rx_stop", tx_a, 1'b1);
                if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_byte", rx_sh, rx_q.pop_front());
                rx_bytes++;
                rx_cnt = -1;
            end
        end
    end

    // Generator-style driver: wait for done high, pulse start for one cycle, then scramble data.
    task automatic send_a(input logic [7:0] d);
        int n;
        n = 0;
        while (!done_a && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        start_a = 1'b1;
        data_a  = d;
        step();
        start_a = 1'b0;
        data_a  = 8'($urandom);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (!done_a && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [9:0] seq_a5;
        int lowcnt, zeros, r0, d0, b0;
        seq_a5 = 10'b1101001010;

        #1 rst_n = 1'b0;
        cmp_en = 1;
        repeat (3) step();
        check("reset_tx",   tx_a,   1'b1);
        check("reset_done", done_a, 1'b1);
        check("reset_busy", busy_a, 1'b0);
        rst_n = 1'b1;
        repeat (2) step();

        // 0xA5 waveform and done-low width
        send_a(8'hA5);
        lowcnt = 0;
        for (int i = 0; i < FRAME_A; i++) begin
            check("a5_tx", tx_a, seq_a5[i/CPB]);
            if (!done_a) lowcnt++;
            step();
        end
        check("a5_done_low", lowcnt, FRAME_A);
        check("a5_done_back", done_a, 1'b1);

        // Back-to-back frames from the generator driver
        r0 = rises;
        send_a(8'h00);
        d0 = done_hi;
        send_a(8'hFF);
        send_a(8'h3C);
        check("b2b_idle_cycles", done_hi - d0, 2);
        wait_idle_a();
        check("b2b_accepts", rises - r0, 3);

        // Start pulse mid-frame must be ignored
        r0 = rises;
        send_a(8'hC3);
        lowcnt = 0;
        for (int i = 0; i < FRAME_A; i++) begin
            if (i == 10) begin
                start_a = 1'b1;
                data_a  = 8'h11;
            end else begin
                start_a = 1'b0;
            end
            if (!done_a) lowcnt++;
            step();
        end
        start_a = 1'b0;
        check("ign_done_low", lowcnt, FRAME_A);
        check("ign_done_at_40", done_a, 1'b1);
        step();
        check("ign_no_queue", busy_a, 1'b0);
        check("ign_accepts", rises - r0, 1);

        // Reset in the middle of a 0x5A frame
        send_a(8'h5A);
        repeat (17) step();
        rst_n = 1'b0;
        #1;
        check("abort_tx",   tx_a,   1'b1);
        check("abort_done", done_a, 1'b1);
        check("abort_busy", busy_a, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        r0    = rises;
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            if (!tx_a) zeros++;
            step();
        end
        check("abort_line_low", zeros, 0);
        check("abort_no_restart", rises - r0, 0);

        // Accept on the very first edge after reset release
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        start_a = 1'b1;
        data_a  = 8'($urandom);
        step();
        start_a = 1'b0;
        check("first_edge_accept", busy_a, 1'b1);
        wait_idle_a();

        // Start held high: one frame per idle window, data changing every cycle
        r0 = rises;
        for (int i = 0; i < 100; i++) begin
            start_a = 1'b1;
            data_a  = 8'($urandom);
            step();
        end
        start_a = 1'b0;
        wait_idle_a();
        check("held_accepts", rises - r0, 3);

        // Two stop bits, data 0x80
        start_b = 1'b1;
        data_b  = 8'h80;
        step();
        start_b = 1'b0;
        data_b  = 8'h00;
        lowcnt  = 0;
        for (int i = 0; i < FRAME_B; i++) begin
            check("b80_tx", tx_b, (i >= 8 * CPB) ? 1'b1 : 1'b0);
            if (!done_b) lowcnt++;
            step();
        end
        check("b80_done_low", lowcnt, FRAME_B);
        check("b80_done_back", done_b, 1'b1);

        // Random loopback traffic with ignored pulses and random idle gaps
        b0 = rx_bytes;
        for (int n = 0; n < 256; n++) begin
            send_a(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 37)) step();
                start_a = 1'b1;
                data_a  = 8'($urandom);
                step();
                start_a = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                wait_idle_a();
                repeat ($urandom_range(0, 5)) step();
            end
        end
        wait_idle_a();
        repeat (3) step();
        check("rx_count", rx_bytes - b0, 256);
        check("rx_queue_empty", rx_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
